// File: rtl/iq_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_mod_pkg
// Brief    : Shared types, widths, quarter-wave sine table and output clamp
//            for the IQ up-converter.
// Revision : 1.0
// ============================================================================
package iq_mod_pkg;

    localparam int SAMPLE_W    = 5;
    localparam int COEF_W      = 6;
    localparam int PHASE_W     = 16;
    localparam int LUT_AW      = 4;
    localparam int FCW_DEFAULT = 16384;
    localparam int PROD_W      = SAMPLE_W + COEF_W;
    localparam int SUM_W       = PROD_W + 1;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0]   coef_t;
    typedef logic signed [PROD_W-1:0]   prod_t;
    typedef logic signed [SUM_W-1:0]    sum_t;

    typedef struct packed {
        logic    clamped;
        sample_t value;
    } sat_t;

    localparam sum_t ROUND_BIAS = sum_t'(1 << (COEF_W - 2));
    localparam sum_t SUM_MAX    = sum_t'((1 << (SAMPLE_W - 1)) - 1);
    localparam sum_t SUM_MIN    = sum_t'(-(1 << (SAMPLE_W - 1)));

    // round(31*sin(2*pi*k/64)), k = 0..16; the extra entry makes the 90 deg point exact.
    localparam coef_t QW_LUT [0:16] = '{
        6'sd0,  6'sd3,  6'sd6,  6'sd9,  6'sd12, 6'sd15, 6'sd17, 6'sd20, 6'sd22,
        6'sd24, 6'sd26, 6'sd27, 6'sd29, 6'sd30, 6'sd30, 6'sd31, 6'sd31
    };

    function automatic sat_t sat_clamp(input sum_t x);
        sum_t sh;
        sat_t r;
        sh = x >>> (COEF_W - 1);
        r.clamped = 1'b0;
        r.value   = sample_t'(sh);
        if (sh > SUM_MAX) begin
            r.clamped = 1'b1;
            r.value   = sample_t'(SUM_MAX);
        end else if (sh < SUM_MIN) begin
            r.clamped = 1'b1;
            r.value   = sample_t'(SUM_MIN);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_mod_nco.sv
`default_nettype none
// ============================================================================
// Module   : iq_mod_nco
// Brief    : Phase accumulator plus quarter-wave LUT; emits cos/sin for each
//            accepted sample, registered in step with pipeline stage 1.
// Revision : 1.0
// ============================================================================
module iq_mod_nco
    import iq_mod_pkg::*;
#(
    parameter int unsigned FCW = FCW_DEFAULT
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  adv,
    input  logic  clr,
    output coef_t cos,
    output coef_t sin
);

    localparam logic [PHASE_W-1:0] C_FCW = PHASE_W'(FCW);
    localparam logic [LUT_AW:0]    C_QTR = (LUT_AW + 1)'(1 << LUT_AW);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase;
    logic [1:0]         w_quad;
    logic [LUT_AW-1:0]  w_idx;
    coef_t              w_s_mag;
    coef_t              w_c_mag;
    coef_t              w_cos;
    coef_t              w_sin;

    // A clear in the same cycle as a sample makes that sample see phase 0.
    always_comb begin
        w_phase = clr ? '0 : r_phase;
        w_quad  = w_phase[PHASE_W-1 -: 2];
        w_idx   = w_phase[PHASE_W-3 -: LUT_AW];
        w_s_mag = QW_LUT[{1'b0, w_idx}];
        w_c_mag = QW_LUT[C_QTR - {1'b0, w_idx}];
        w_cos   = w_c_mag;
        w_sin   = w_s_mag;
        case (w_quad)
            2'd0: begin w_cos = w_c_mag;  w_sin = w_s_mag;  end
            2'd1: begin w_cos = -w_s_mag; w_sin = w_c_mag;  end
            2'd2: begin w_cos = -w_c_mag; w_sin = -w_s_mag; end
            2'd3: begin w_cos = w_s_mag;  w_sin = -w_c_mag; end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_phase <= '0;
            cos     <= '0;
            sin     <= '0;
        end else begin
            if (clr || adv) begin
                r_phase <= w_phase + (adv ? C_FCW : '0);
            end
            if (adv) begin
                cos <= w_cos;
                sin <= w_sin;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_mod.sv
`default_nettype none
// ============================================================================
// Module   : iq_mod
// Brief    : Complex up-converter: rotates baseband I/Q by the NCO through a
//            3-stage multiply / add-round-saturate pipeline.
// Revision : 1.0
// ============================================================================
module iq_mod
    import iq_mod_pkg::*;
#(
    parameter int unsigned FCW = FCW_DEFAULT
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    bb_valid,
    input  sample_t I_BB,
    input  sample_t Q_BB,
    input  logic    phase_clr,
    input  logic    sat_clr,
    output logic    mod_iq_valid,
    output sample_t I_IF,
    output sample_t Q_IF,
    output logic    sat_flag
);

    coef_t   w_cos;
    coef_t   w_sin;
    sample_t r_i1;
    sample_t r_q1;
    logic    r_v1;
    logic    r_v2;
    prod_t   r_ic;
    prod_t   r_qs;
    prod_t   r_is;
    prod_t   r_qc;
    sum_t    w_i_sum;
    sum_t    w_q_sum;
    sat_t    w_i_sat;
    sat_t    w_q_sat;

    iq_mod_nco #(
        .FCW (FCW)
    ) u_nco (
        .clk    (clk),
        .resetn (resetn),
        .adv    (bb_valid),
        .clr    (phase_clr),
        .cos    (w_cos),
        .sin    (w_sin)
    );

    always_comb begin
        w_i_sum = sum_t'(r_ic) - sum_t'(r_qs) + ROUND_BIAS;
        w_q_sum = sum_t'(r_is) + sum_t'(r_qc) + ROUND_BIAS;
        w_i_sat = sat_clamp(w_i_sum);
        w_q_sat = sat_clamp(w_q_sum);
    end

    // Data registers load only with their stage valid so outputs hold while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_i1         <= '0;
            r_q1         <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_ic         <= '0;
            r_qs         <= '0;
            r_is         <= '0;
            r_qc         <= '0;
            mod_iq_valid <= 1'b0;
            I_IF         <= '0;
            Q_IF         <= '0;
            sat_flag     <= 1'b0;
        end else begin
            r_v1         <= bb_valid;
            r_v2         <= r_v1;
            mod_iq_valid <= r_v2;
            if (bb_valid) begin
                r_i1 <= I_BB;
                r_q1 <= Q_BB;
            end
            if (r_v1) begin
                r_ic <= prod_t'(r_i1) * prod_t'(w_cos);
                r_qs <= prod_t'(r_q1) * prod_t'(w_sin);
                r_is <= prod_t'(r_i1) * prod_t'(w_sin);
                r_qc <= prod_t'(r_q1) * prod_t'(w_cos);
            end
            if (r_v2) begin
                I_IF <= w_i_sat.value;
                Q_IF <= w_q_sat.value;
            end
            if (r_v2 && (w_i_sat.clamped || w_q_sat.clamped)) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
